// File: rtl/perm_pkg.sv
// perm_pkg: shared constants and FSM state type for the Keccak permutation scheduler
package perm_pkg;
  localparam int NROUNDS = 24;
  localparam int ROUNDS_PER_CYCLE = 3;
  localparam int CYCLES = NROUNDS / ROUNDS_PER_CYCLE;
  localparam int CNT_W = $clog2(CYCLES);
  localparam int TAG_W_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant search, round-robin from i_ptr+1 or fixed priority under PERM_ARB_FIXED_PRIO_EN
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);
  localparam int SW = $clog2(NREQ);
  function automatic int wrap(input int a);
    return a % NREQ;
  endfunction
`ifdef PERM_ARB_FIXED_PRIO_EN
  // lowest valid index wins; scanning downwards leaves the lowest one last
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        o_any = 1'b1;
        o_idx = SW'(k);
      end
    end
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end
`else
  // first valid requester after the previous winner, wrapping around
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!o_any && i_req[wrap(int'(i_ptr) + k)]) begin
        o_any = 1'b1;
        o_idx = SW'(wrap(int'(i_ptr) + k));
      end
    end
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end
`endif
endmodule

// File: rtl/perm_arbiter.sv
// perm_arbiter: shares one 3-rounds-per-cycle Keccak-f[1600] core between NREQ channels; PERM_ARB_FIXED_PRIO_EN selects fixed priority
module perm_arbiter
  import perm_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*TAG_W-1:0]   i_req_tag,
  output logic [NREQ-1:0]         o_req_ready,
  output logic                    o_core_load,
  output logic [$clog2(NREQ)-1:0] o_core_sel,
  output logic                    o_core_run,
  output logic [4:0]              o_core_round,
  output logic [NREQ-1:0]         o_resp_valid,
  input  logic [NREQ-1:0]         i_resp_ready,
  output logic [TAG_W-1:0]        o_resp_tag,
  output logic                    o_busy
);
  localparam int SW = $clog2(NREQ);
  if (CYCLES * ROUNDS_PER_CYCLE != NROUNDS) begin : g_bad_rounds
    $error("NROUNDS must be a multiple of ROUNDS_PER_CYCLE");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    r_owner;
  logic [TAG_W-1:0] r_tag;
  logic [NREQ-1:0]  w_grant;
  logic [SW-1:0]    w_win;
  logic [SW-1:0]    w_ptr;
  logic             w_any;
  logic             w_resp_hs;
  logic             w_req_hs;
`ifdef PERM_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [SW-1:0] r_last;
  assign w_ptr = r_last;
  // the pointer only moves when a grant is actually taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_last <= SW'(NREQ - 1);
    else if (w_req_hs) r_last <= w_win;
  end
`endif
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req  (i_req_valid),
    .i_ptr  (w_ptr),
    .o_grant(w_grant),
    .o_idx  (w_win),
    .o_any  (w_any)
  );
  // a new job may load when idle, or when the held result is taken this same cycle
  assign w_resp_hs   = (r_state == HOLD) && i_resp_ready[r_owner];
  assign w_req_hs    = !reset && ((r_state == IDLE) || w_resp_hs) && w_any;
  assign o_req_ready  = w_req_hs ? w_grant : '0;
  assign o_core_load  = w_req_hs;
  assign o_core_run   = w_req_hs || (r_state == BUSY);
  assign o_core_sel   = w_req_hs ? w_win : (r_state == IDLE ? '0 : r_owner);
  assign o_core_round = (r_state == BUSY) ? 5'(ROUNDS_PER_CYCLE * int'(r_cnt)) : 5'd0;
  assign o_resp_valid = (r_state == HOLD) ? (NREQ'(1) << r_owner) : '0;
  assign o_resp_tag   = (r_state == HOLD) ? r_tag : '0;
  assign o_busy       = (r_state != IDLE);
  // job FSM: load, CYCLES-1 recirculation cycles, then hold the result until accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_tag   <= '0;
    end else if (w_req_hs) begin
      r_state <= BUSY;
      r_cnt   <= CNT_W'(1);
      r_owner <= w_win;
      r_tag   <= i_req_tag[w_win*TAG_W +: TAG_W];
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(CYCLES - 1)) r_state <= HOLD;
    end else if (w_resp_hs) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: doc/perm_arbiter.md
# perm_arbiter

Scheduler that shares one iterative Keccak-f[1600] permutation core (3 rounds per clock, 24 rounds) between NREQ hash channels. It grants one requester at a time using round-robin, and drives the core's load select, run enable and round index for the 8 compute cycles. It then holds the result until the owning channel accepts it. It sits between the per-channel sponge/absorb blocks and the shared permutation datapath. The 1600-bit state mux and the core itself live outside this block.

## Interface
- NREQ, 2, number of requesting channels (2..8)
- TAG_W, 8, tag width carried per job
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  channel i has a state ready to permute
- req_tag  in  NREQ*TAG_W  job tag per channel, slice i = [i*TAG_W +: TAG_W]
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- core_load  out  1  core takes state from the mux input this cycle, not its recirculation register
- core_sel  out  $clog2(NREQ)  mux select of the channel being loaded or processed
- core_run  out  1  core register update enable
- core_round  out  5  first round index applied this cycle (0,3,…,21), for the iota constants
- resp_valid  out  NREQ  one-hot: core output is the finished state for channel i
- resp_ready  in  NREQ  channel accepts result
- resp_tag  out  TAG_W  tag of the finished job
- busy  out  1  core owned (BUSY or HOLD)

## Operation
- States:
  - IDLE: no job.
  - BUSY: cnt = 1..7.
  - HOLD: result waiting for the owning channel.
- Accept opportunity: in IDLE, or in HOLD in the same cycle as the response handshake.
- On an accept opportunity with any req_valid set:
  - req_ready asserts for the arbitration winner only (combinational on req_valid).
  - core_load=1, core_run=1, core_sel=winner, core_round=0.
  - Winner's tag is latched; owner=winner; cnt←1; next state BUSY.
- BUSY:
  - core_run=1, core_load=0, core_sel=owner, core_round=3*cnt.
  - cnt increments each cycle; at cnt==7 the next state is HOLD.
- HOLD:
  - core_run=0; resp_valid[owner]=1; resp_tag=latched tag.
  - Held stable until resp_ready[owner].
  - On the response handshake: an accept opportunity exists this cycle; with no winner, next state is IDLE.
- resp_ready on non-owner bits is ignored.
- req_valid dropping before the grant is legal: that requester is simply not granted.
- Round-robin pointer:
  - Search starts at last_grant+1 mod NREQ; the first valid wins.
  - last_grant updates only on a request handshake.
- Constants: NROUNDS=24, ROUNDS_PER_CYCLE=3, CYCLES=NROUNDS/ROUNDS_PER_CYCLE=8. The divisibility is checked at elaboration.
- core_round width is 5 bits; max value 21; no wrap.

## Timing
- Reset values:
  - state=IDLE, cnt=0, last_grant=NREQ-1 (requester 0 wins first), tag=0, owner=0.
  - All outputs 0: req_ready, core_*, resp_valid, resp_tag, busy.
- Reset asserted mid-job aborts the job immediately. No response is produced.
- Latency: request handshake at cycle T → resp_valid at T+8.
- Back-to-back throughput: one job per 8 cycles plus the response-wait cycles. The minimum is 8 cycles per job when the response handshake coincides with the next load.
- Simultaneous response handshake and new request: both complete in the same cycle. The core reloads at the edge, so the old result is valid only in that cycle.
- busy=1 from the cycle after the request handshake until the cycle of the response handshake inclusive.

## Configuration
- PERM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins; last_grant is not implemented.
  - Undefined (default): round-robin as above.

## Structure
- Package perm_pkg holds:
  - NROUNDS, ROUNDS_PER_CYCLE, CYCLES, TAG_W default.
  - State enum (IDLE, BUSY, HOLD), shared with the core wrapper.
- One sub-module: rr_arbiter (NREQ-wide request vector plus pointer in, one-hot grant out). It also contains the fixed-priority variant under the macro.

## Test plan
- Single request: reset, req_valid=01, tag=8'hA5 at cycle 5.
  - Required: core_load at 5.
  - core_round=0,3,…,21 over cycles 5..12.
  - resp_valid=01, resp_tag=A5 at 13.
- Contention: both channels valid continuously, resp_ready=11.
  - Round-robin: grants alternate 0,1,0,1 with an 8-cycle spacing.
  - Fixed-priority build: only 0 is granted.
- Response backpressure: resp_ready=0 for 20 cycles.
  - Required: resp_valid and resp_tag stable, core_run=0, req_ready=0 throughout.
  - The new job loads in the cycle resp_ready rises.
- Simultaneous handshake: channel 1 valid while channel 0's resp_ready rises.
  - Required: req_ready=10 and core_load=1 in that same cycle.
  - Channel 1's response arrives 8 cycles later.
- Reset mid-job: assert reset at cnt=4.
  - Required: all outputs 0 immediately.
  - After release, no stale resp_valid; the next request is served from round 0.
